temporizer_core: RTL and testbench
==================================

// Module: temporizer_core
// PURPOSE
//  Countdown timer that produces the seconds value and run state consumed by
//  the display/frame-memory writer stage.
//  Supports load (preset), start/stop toggle, clear and terminal-count detect.
//  Generates a 1 s tick from the system clock through a prescaler.
//  All outputs are registered and change only on clk rising edges.
// PARAMETERS
//  TICK_DIV  100000000  clk cycles per second tick (>=2; benches use 4)
//  MAX_TIME  5999       largest loadable value in seconds (99:59)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  clear       in   1   sync clear: time_out<=0, state<=STOPPED
//  load        in   1   sync load of load_value (level-sampled every cycle)
//  load_value  in  16   preset in seconds; clamped to MAX_TIME
//  start_stop  in   1   level; rising edge toggles COUNTING/STOPPED
//  time_out    out 16   remaining seconds, 0..MAX_TIME
//  state       out  2   00 COUNTING, 01 STOPPED, 11 FINISHED (10 never driven)
//  tick        out  1   1-cycle pulse on each prescaler wrap (COUNTING/FINISHED)
//  done        out  1   1-cycle pulse on the cycle state enters FINISHED
// BEHAVIOUR
//  Reset (async, rst_n=0): state=01, time_out=0, prescaler=0, tick=0, done=0,
//   start_stop edge register=0. Reset mid-count aborts with no done pulse.
//  Edge detect: ss_q <= start_stop every cycle; edge = start_stop & ~ss_q.
//   A level held high produces one edge only.
//  Per-cycle priority: clear > load > edge > prescaler tick.
//  clear: any state -> STOPPED, time_out=0, prescaler=0; tick/done stay 0.
//  load: honoured in STOPPED and FINISHED only (ignored in COUNTING):
//   time_out <= min(load_value, MAX_TIME); state -> STOPPED; prescaler=0.
//  STOPPED:
//   - edge and time_out!=0 -> COUNTING next cycle; prescaler keeps its value.
//   - edge and time_out==0 -> stays STOPPED.
//   - prescaler frozen; tick=0.
//  COUNTING:
//   - edge -> STOPPED next cycle; no decrement that cycle, even if the
//     prescaler is at TICK_DIV-1 (it holds there; first decrement then occurs
//     on the first COUNTING cycle after resume).
//   - else the prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0,
//     tick=1 for that cycle, and time_out decrements by 1.
//   - If the decrement makes time_out 0: state -> FINISHED and done=1 in
//     the same registered update.
//  FINISHED:
//   - time_out stays 0; edge ignored.
//   - Prescaler free-runs; tick keeps pulsing every TICK_DIV cycles
//     (colour-cycle pacing).
//   - Exits only via load (-> STOPPED) or clear.
//  Latency: input sampled at edge n is reflected on outputs after edge n.
//  Arithmetic: time_out is unsigned 16-bit and never underflows (decrement
//   only when >=1). Prescaler width is $clog2(TICK_DIV).
//  Simultaneous events: clear with load -> clear wins. Load with edge in
//   STOPPED -> load wins and the edge is consumed (no start).
// TESTING (TICK_DIV=4, MAX_TIME=5999)
//  1 Reset: rst_n=0 asynchronously mid-count -> state=01, time_out=0,
//    tick=0, done=0 immediately, without waiting for clk.
//  2 Load 3, pulse start_stop -> state=00; time_out 3->2->1->0 at 4-cycle
//    spacing. On the 0 transition: state=11, done=1 for exactly 1 cycle;
//    tick continues every 4 cycles.
//  3 Load 9000 -> time_out=5999; load asserted while COUNTING -> ignored.
//  4 Count from 10; stop edge on the wrap cycle -> no decrement, state=01.
//    Restart -> next decrement on the first COUNTING cycle.
//  5 start_stop held high 20 cycles from STOPPED(time 5) -> a single
//    transition to 00. Edge with time_out=0 -> stays 01.
//  6 clear+load same cycle (load_value 7) -> time_out=0, state=01.
//    clear in FINISHED -> state=01.

Source files
------------

// File: rtl/temporizer_core.sv
// Countdown timer core: holds the remaining seconds and run state for the
// display writer, paced by a prescaler that wraps once per TICK_DIV clocks.
// Supports preset load (clamped to MAX_TIME), start/stop toggle on the rising
// edge of start_stop, synchronous clear and terminal-count detection.
module temporizer_core #(
  parameter int TICK_DIV = 100000000,
  parameter int MAX_TIME = 5999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start_stop,
  output logic [15:0] time_out,
  output logic [1:0]  state,
  output logic        tick,
  output logic        done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   MAX_VAL    = 16'(MAX_TIME);

  typedef enum logic [1:0] {
    COUNTING = 2'b00,
    STOPPED  = 2'b01,
    FINISHED = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          ss_q;
  logic          ss_edge;

  // Presets above the display range saturate to the largest loadable value.
  function automatic logic [15:0] clamp_time(input logic [15:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // A held start_stop level yields a single toggle request.
  assign ss_edge = start_stop & ~ss_q;

  // Next-state logic; priority is clear, then load, then start/stop edge,
  // then prescaler advance.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (clear) begin
      state_d = STOPPED;
      time_d  = '0;
      presc_d = '0;
    end else if (load && (state_q != COUNTING)) begin
      // The edge in the same cycle is consumed by the load.
      state_d = STOPPED;
      time_d  = clamp_time(load_value);
      presc_d = '0;
    end else begin
      case (state_q)
        STOPPED: begin
          // Prescaler is frozen so a resume continues the partial second.
          if (ss_edge && (time_q != 16'd0)) state_d = COUNTING;
        end
        COUNTING: begin
          if (ss_edge) begin
            // Stop wins over a pending wrap; prescaler holds its value.
            state_d = STOPPED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (time_q != 16'd0) begin
              time_d = time_q - 16'd1;
              if (time_q == 16'd1) begin
                state_d = FINISHED;
                done_d  = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        FINISHED: begin
          // Prescaler keeps running so tick paces the display colour cycle.
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: state_d = STOPPED;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      time_q  <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      ss_q    <= start_stop;
    end
  end

  assign time_out = time_q;
  assign state    = state_q;
  assign tick     = tick_q;
  assign done     = done_q;

endmodule

// File: tb/tb_temporizer_core.sv
// Bench for temporizer_core: fixed vector table, hand-written corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_temporizer_core;

  localparam int TICK_DIV = 4;
  localparam int MAX_TIME = 5999;
  localparam int M_RUN    = 0;
  localparam int M_STOP   = 1;
  localparam int M_FIN    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic        start_stop;
  logic [15:0] time_out;
  logic [1:0]  state;
  logic        tick;
  logic        done;

  temporizer_core #(.TICK_DIV(TICK_DIV), .MAX_TIME(MAX_TIME)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
    .load_value(load_value), .start_stop(start_stop),
    .time_out(time_out), .state(state), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state: seconds left, mode, cycles elapsed in the
  // current second, last start_stop level, and the pulses of this cycle.
  int m_secs, m_mode, m_phase;
  bit m_prev_ss, m_tick, m_done;

  typedef struct {
    bit clr; bit ld; int lv; bit ss;
    int t; int st; bit tk; bit dn;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(bit clr, bit ld, int lv, bit ss,
                              int t, int st, bit tk, bit dn);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.ss = ss;
    v.t = t; v.st = st; v.tk = tk; v.dn = dn;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_secs = 0; m_mode = M_STOP; m_phase = 0;
    m_prev_ss = 1'b0; m_tick = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit l, input int lv, input bit ss);
    bit rise;
    rise = ss && !m_prev_ss;
    m_prev_ss = ss;
    m_tick = 1'b0;
    m_done = 1'b0;
    if (c) begin
      m_secs = 0; m_mode = M_STOP; m_phase = 0;
    end else if (l && m_mode != M_RUN) begin
      m_secs = (lv > MAX_TIME) ? MAX_TIME : lv;
      m_mode = M_STOP; m_phase = 0;
    end else if (m_mode == M_STOP) begin
      if (rise && m_secs > 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN && rise) begin
      m_mode = M_STOP;
    end else begin
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        m_tick = 1'b1;
        if (m_mode == M_RUN) begin
          m_secs--;
          if (m_secs == 0) begin
            m_mode = M_FIN;
            m_done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    check("model.time_out", int'(time_out), m_secs);
    check("model.state", int'(state), m_mode);
    check("model.tick", int'(tick), int'(m_tick));
    check("model.done", int'(done), int'(m_done));
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step(clear, load, int'(load_value), start_stop);
    #1;
    check_model();
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit ss);
    clear = c; load = l; load_value = 16'(lv); start_stop = ss;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #12;
    check("reset.state", int'(state), 1);
    check("reset.time_out", int'(time_out), 0);
    check("reset.tick", int'(tick), 0);
    check("reset.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: load 3 and count to FINISHED, clamp, load ignored while
    // counting, clear beating load, edge with zero time.
    vq.push_back(mk(0,1,3,0,    3,1,0,0));
    vq.push_back(mk(0,0,0,1,    3,0,0,0));
    vq.push_back(mk(0,0,0,1,    3,0,0,0));
    vq.push_back(mk(0,0,0,0,    3,0,0,0));
    vq.push_back(mk(0,0,0,0,    3,0,0,0));
    vq.push_back(mk(0,0,0,0,    2,0,1,0));
    vq.push_back(mk(0,0,0,0,    2,0,0,0));
    vq.push_back(mk(0,0,0,0,    2,0,0,0));
    vq.push_back(mk(0,0,0,0,    2,0,0,0));
    vq.push_back(mk(0,0,0,0,    1,0,1,0));
    vq.push_back(mk(0,0,0,0,    1,0,0,0));
    vq.push_back(mk(0,0,0,0,    1,0,0,0));
    vq.push_back(mk(0,0,0,0,    1,0,0,0));
    vq.push_back(mk(0,0,0,0,    0,3,1,1));
    vq.push_back(mk(0,0,0,0,    0,3,0,0));
    vq.push_back(mk(0,0,0,0,    0,3,0,0));
    vq.push_back(mk(0,0,0,0,    0,3,0,0));
    vq.push_back(mk(0,0,0,0,    0,3,1,0));
    vq.push_back(mk(0,1,9000,0, 5999,1,0,0));
    vq.push_back(mk(0,0,0,1,    5999,0,0,0));
    vq.push_back(mk(0,1,5,0,    5999,0,0,0));
    vq.push_back(mk(1,1,7,0,    0,1,0,0));
    vq.push_back(mk(0,0,0,1,    0,1,0,0));
    vq.push_back(mk(0,0,0,0,    0,1,0,0));
    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].ld, vq[i].lv, vq[i].ss);
      run_cycle();
      check($sformatf("vec%0d.time_out", i), int'(time_out), vq[i].t);
      check($sformatf("vec%0d.state", i), int'(state), vq[i].st);
      check($sformatf("vec%0d.tick", i), int'(tick), int'(vq[i].tk));
      check($sformatf("vec%0d.done", i), int'(done), int'(vq[i].dn));
    end

    // Stop edge on the wrap cycle: no decrement; resume decrements at once.
    drive(0, 1, 10, 0); run_cycle();
    drive(0, 0, 0, 1);  run_cycle();
    drive(0, 0, 0, 0);
    repeat (3) run_cycle();
    drive(0, 0, 0, 1);  run_cycle();
    check("stopwrap.state", int'(state), 1);
    check("stopwrap.time_out", int'(time_out), 10);
    check("stopwrap.tick", int'(tick), 0);
    drive(0, 0, 0, 0);  run_cycle();
    drive(0, 0, 0, 1);  run_cycle();
    check("resume.state", int'(state), 0);
    drive(0, 0, 0, 0);  run_cycle();
    check("resume.time_out", int'(time_out), 9);
    check("resume.tick", int'(tick), 1);

    // Held start_stop from STOPPED(5): exactly one transition to COUNTING.
    drive(0, 0, 0, 1);  run_cycle();
    drive(0, 1, 5, 0);  run_cycle();
    check("reload.time_out", int'(time_out), 5);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      run_cycle();
      check($sformatf("held%0d.state", k), int'(state), 0);
    end

    // Asynchronous reset in the middle of a count.
    #3;
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    check("areset.state", int'(state), 1);
    check("areset.time_out", int'(time_out), 0);
    check("areset.tick", int'(tick), 0);
    check("areset.done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    check("areset_hold.state", int'(state), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) run_cycle();

    // Reach FINISHED from 1, then clear out of it.
    drive(0, 1, 1, 0);  run_cycle();
    drive(0, 0, 0, 1);  run_cycle();
    drive(0, 0, 0, 0);
    repeat (3) run_cycle();
    run_cycle();
    check("fin.state", int'(state), 3);
    check("fin.done", int'(done), 1);
    drive(1, 0, 0, 0);  run_cycle();
    check("finclear.state", int'(state), 1);
    check("finclear.time_out", int'(time_out), 0);

    // Randomized traffic against the model.
    drive(0, 0, 0, 0);
    for (int k = 0; k < 2000; k++) begin
      clear = ($urandom_range(0, 49) == 0);
      load  = ($urandom_range(0, 14) == 0);
      load_value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                               : 16'($urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) start_stop = ~start_stop;
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
